// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU bus: one read or write at a time against an
// internal single-port RAM, completed after WAIT_STATES wait cycles with an ack pulse.
//
// state     | meaning
// ST_IDLE   | waiting for req_rdwr; the request is latched on the edge it is seen
// ST_WAIT   | wait-state down-counter running; terminal count 1 moves to ST_ACCESS
// ST_ACCESS | latched access performed on the next edge; ack/bus_err issued
module cpu_bus_responder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int WAIT_STATES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rdwr,
    input  logic                  which_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ack,
    output logic                  busy,
    output logic                  bus_err
);
    localparam int         MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic       WHICH_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [3:0]                wait_cnt;
    logic [3:0]                wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0]     lat_addr;
    logic                      lat_write;
    logic [DATA_WIDTH-1:0]     lat_data;
    logic                      latch_en;
    logic                      mem_we;
    logic                      rd_load;
    logic                      ack_nxt;
    logic                      err_nxt;
    logic                      mapped;
    logic [MEM_DEPTH_LOG2-1:0] mem_idx;
    logic [DATA_WIDTH-1:0]     rd_data_nxt;
    logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];

    // Only the bottom MEM_DEPTH words of the address space are backed by RAM.
    assign mapped      = ((lat_addr >> MEM_DEPTH_LOG2) == '0);
    assign mem_idx     = lat_addr[MEM_DEPTH_LOG2-1:0];
    assign rd_data_nxt = mapped ? mem[mem_idx] : '1;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        latch_en     = 1'b0;
        mem_we       = 1'b0;
        rd_load      = 1'b0;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_rdwr) begin
                    latch_en     = 1'b1;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = (WAIT_LOAD != 4'd0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_IDLE;
                ack_nxt   = 1'b1;
                err_nxt   = !mapped;
                mem_we    = mapped && lat_write;
                rd_load   = !lat_write;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            ack      <= 1'b0;
            bus_err  <= 1'b0;
            busy     <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            ack      <= ack_nxt;
            bus_err  <= err_nxt;
            busy     <= (state_nxt != ST_IDLE);
            if (rd_load) begin
                rd_data <= rd_data_nxt;
            end
        end
    end

    // Request fields are frozen for the whole transaction; bus changes while busy are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_data  <= '0;
        end else if (latch_en) begin
            lat_addr  <= addr;
            lat_write <= (which_rdwr == WHICH_WRITE);
            lat_data  <= wr_data;
        end
    end

    // RAM has no reset; an abort clears state before mem_we can assert.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= lat_data;
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance,
// each checked every cycle against a transaction-level model plus literal expectations.
module tb_cpu_bus_responder;
    localparam int WS_A = 2;
    localparam int WS_B = 0;

    logic       clk;
    logic       rst;
    logic       req_v   [2];
    logic       wr_v    [2];
    logic [15:0] addr_v [2];
    logic [7:0] wd_v    [2];
    logic [7:0] rd_v    [2];
    logic       ack_v   [2];
    logic       busy_v  [2];
    logic       err_v   [2];

    int n_tests = 0;
    int n_fail  = 0;

    cpu_bus_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_DEPTH_LOG2(12), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .rst(rst), .req_rdwr(req_v[0]), .which_rdwr(wr_v[0]), .addr(addr_v[0]),
        .wr_data(wd_v[0]), .rd_data(rd_v[0]), .ack(ack_v[0]), .busy(busy_v[0]), .bus_err(err_v[0]));

    cpu_bus_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_DEPTH_LOG2(12), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .rst(rst), .req_rdwr(req_v[1]), .which_rdwr(wr_v[1]), .addr(addr_v[1]),
        .wr_data(wd_v[1]), .rd_data(rd_v[1]), .ack(ack_v[1]), .busy(busy_v[1]), .bus_err(err_v[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: a request seen while free completes WS+1 edges later.
    int         cyc = 0;
    bit         m_busy  [2] = '{0, 0};
    int         m_done  [2] = '{0, 0};
    logic [15:0] m_addr [2];
    bit         m_wr    [2];
    logic [7:0] m_wd    [2];
    logic [7:0] m_rd    [2] = '{8'h00, 8'h00};
    bit         m_rdk   [2] = '{1, 1};
    bit         m_ack   [2] = '{0, 0};
    bit         m_err   [2] = '{0, 0};
    logic [7:0] m_mem   [2][4096];
    bit         m_known [2][4096];

    function automatic int ws_of(input int k);
        return (k == 0) ? WS_A : WS_B;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int k = 0; k < 2; k++) begin
                    m_busy[k] = 0; m_ack[k] = 0; m_err[k] = 0;
                    m_rd[k] = 8'h00; m_rdk[k] = 1;
                end
            end else begin
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    m_ack[k] = 0;
                    m_err[k] = 0;
                    if (m_busy[k]) begin
                        if (cyc == m_done[k]) begin
                            m_busy[k] = 0;
                            m_ack[k]  = 1;
                            if (m_addr[k] >= 16'd4096) begin
                                m_err[k] = 1;
                                if (!m_wr[k]) begin
                                    m_rd[k] = 8'hFF; m_rdk[k] = 1;
                                end
                            end else if (m_wr[k]) begin
                                m_mem[k][m_addr[k][11:0]]   = m_wd[k];
                                m_known[k][m_addr[k][11:0]] = 1;
                            end else begin
                                m_rd[k]  = m_mem[k][m_addr[k][11:0]];
                                m_rdk[k] = m_known[k][m_addr[k][11:0]];
                            end
                        end
                    end else if (req_v[k]) begin
                        m_busy[k] = 1;
                        m_done[k] = cyc + ws_of(k) + 1;
                        m_addr[k] = addr_v[k];
                        m_wr[k]   = wr_v[k];
                        m_wd[k]   = wd_v[k];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_ack%0d", k), 32'(ack_v[k]), 32'(m_ack[k]));
                chk($sformatf("model_busy%0d", k), 32'(busy_v[k]), 32'(m_busy[k]));
                chk($sformatf("model_err%0d", k), 32'(err_v[k]), 32'(m_err[k]));
                if (m_rdk[k]) chk($sformatf("model_rd%0d", k), 32'(rd_v[k]), 32'(m_rd[k]));
            end
        end
    end

    task automatic wait_ack(input int k, output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!ack_v[k] && n < 40);
        if (!ack_v[k]) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout inst=%0d waited=%0d cycles", k, n);
        end
    endtask

    task automatic access(input int k, input bit wr, input logic [15:0] a, input logic [7:0] d,
                          output int n);
        req_v[k] = 1'b1; wr_v[k] = wr; addr_v[k] = a; wd_v[k] = d;
        wait_ack(k, n);
        req_v[k] = 1'b0;
    endtask

    logic [7:0] b2b_exp [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            req_v[k] = 1'b0; wr_v[k] = 1'b0; addr_v[k] = '0; wd_v[k] = '0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;

        // reset held with a pending write of 0x11 to 0x0000
        req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 16'h0000; wd_v[0] = 8'h11;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack_v[0]), 32'd0);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_rd", 32'(rd_v[0]), 32'h00);
        rst = 1'b1;
        wait_ack(0, n);
        req_v[0] = 1'b0;
        chk("rst_release_latency", 32'(n), 32'd4);

        access(0, 1'b1, 16'h0123, 8'h5A, n);
        chk("wr_latency", 32'(n), 32'd4);
        chk("wr_err", 32'(err_v[0]), 32'd0);
        access(0, 1'b0, 16'h0123, 8'h00, n);
        chk("rd_latency", 32'(n), 32'd4);
        chk("rd_0123", 32'(rd_v[0]), 32'h5A);
        chk("rd_err", 32'(err_v[0]), 32'd0);

        access(0, 1'b0, 16'h1000, 8'h00, n);
        chk("unmapped_rd", 32'(rd_v[0]), 32'hFF);
        chk("unmapped_rd_err", 32'(err_v[0]), 32'd1);
        access(0, 1'b1, 16'h2123, 8'h77, n);
        chk("unmapped_wr_err", 32'(err_v[0]), 32'd1);
        chk("unmapped_wr_rd_hold", 32'(rd_v[0]), 32'hFF);
        access(0, 1'b0, 16'h0123, 8'h00, n);
        chk("alias_untouched", 32'(rd_v[0]), 32'h5A);

        access(0, 1'b1, 16'h0001, 8'h22, n);
        access(0, 1'b1, 16'h0002, 8'h33, n);
        req_v[0] = 1'b1; wr_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_v[0] = 16'(i);
            wait_ack(0, n);
            chk($sformatf("b2b_gap%0d", i), 32'(n), 32'd4);
            chk($sformatf("b2b_rd%0d", i), 32'(rd_v[0]), 32'(b2b_exp[i]));
        end
        req_v[0] = 1'b0;

        // zero-wait-state instance; address changed while busy must be ignored
        access(1, 1'b1, 16'h0042, 8'h9C, n);
        chk("ws0_wr_latency", 32'(n), 32'd2);
        req_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 16'h0042;
        @(posedge clk);
        @(negedge clk);
        chk("ws0_busy", 32'(busy_v[1]), 32'd1);
        chk("ws0_no_ack_yet", 32'(ack_v[1]), 32'd0);
        addr_v[1] = 16'h0123;
        @(posedge clk);
        @(negedge clk);
        req_v[1] = 1'b0;
        chk("ws0_ack", 32'(ack_v[1]), 32'd1);
        chk("ws0_orig_addr", 32'(rd_v[1]), 32'h9C);

        // reset during WAIT of a write must not commit it
        access(0, 1'b1, 16'h0010, 8'h3C, n);
        req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 16'h0010; wd_v[0] = 8'hA5;
        @(posedge clk);
        #2;
        chk("abort_busy_before", 32'(busy_v[0]), 32'd1);
        rst = 1'b0;
        req_v[0] = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_ack", 32'(ack_v[0]), 32'd0);
        chk("abort_rd", 32'(rd_v[0]), 32'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        access(0, 1'b0, 16'h0010, 8'h00, n);
        chk("abort_prior", 32'(rd_v[0]), 32'h3C);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
